// File: rtl/sync_fifo_pkg.sv
// Shared word-width helper, read-mode encodings and parameter legality checks
// for the synchronous sample FIFO family.
package sync_fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  function automatic int fifo_word_w(input int data_width, input int ch_num);
    return data_width * ch_num;
  endfunction

  function automatic bit addr_width_ok(input int addr_width);
    return (addr_width >= 4) && (addr_width <= 10);
  endfunction

  function automatic bit mode_ok(input int fwft);
    return (fwft == MODE_STD) || (fwft == MODE_FWFT);
  endfunction

  function automatic bit almost_full_ok(input int af_num, input int addr_width);
    return (af_num >= 1) && (af_num <= (1 << addr_width));
  endfunction

  function automatic bit almost_empty_ok(input int ae_num, input int addr_width);
    return (ae_num >= 0) && (ae_num <= (1 << addr_width) - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_dpram.sv
// Distributed RAM: synchronous write port, asynchronous read port, no reset.
// Read data follows rd_addr combinationally; no flow control at this level.
module sync_fifo_dpram #(
  parameter int WORD_W     = 48,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_W-1:0]     rd_data
);

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_sample_fifo.sv
// Lock-stepped multichannel sample FIFO; flags valid 1 cycle after the edge, rd_data 1 cycle after rd_en (FWFT: head shown when !empty).
// Writes while full and reads while empty are dropped and latched as sticky errors; SYNC_SAMPLE_FIFO_FLUSH_EN adds a flush port.
module sync_sample_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 24,
  parameter int CH_NUM           = 2,
  parameter int ADDR_WIDTH       = 8,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 11,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic [CH_NUM*DATA_WIDTH-1:0] wr_data,
  input  logic                         wr_en,
  output logic                         full,
  output logic                         almost_full,
  output logic [CH_NUM*DATA_WIDTH-1:0] rd_data,
  input  logic                         rd_en,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [ADDR_WIDTH:0]          water_level,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
);

  localparam int WORD_W = fifo_word_w(DATA_WIDTH, CH_NUM);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int LW     = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = LW'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = LW'(ALMOST_EMPTY_NUM);

  if (!addr_width_ok(ADDR_WIDTH)) begin : g_bad_addr_width
    $fatal(1, "sync_sample_fifo: ADDR_WIDTH must be within 4..10");
  end
  if (!mode_ok(FWFT)) begin : g_bad_fwft
    $fatal(1, "sync_sample_fifo: FWFT must be 0 or 1");
  end
  if (!almost_full_ok(ALMOST_FULL_NUM, ADDR_WIDTH)) begin : g_bad_af
    $fatal(1, "sync_sample_fifo: ALMOST_FULL_NUM must be within 1..DEPTH");
  end
  if (!almost_empty_ok(ALMOST_EMPTY_NUM, ADDR_WIDTH)) begin : g_bad_ae
    $fatal(1, "sync_sample_fifo: ALMOST_EMPTY_NUM must be within 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   level, level_nxt;
  logic [WORD_W-1:0]     ram_rd_data;
  logic                  wr_acc, rd_acc, ram_we;

  // Acceptance uses the registered flags, i.e. the pre-edge level only.
  assign wr_acc      = wr_en && !full;
  assign rd_acc      = rd_en && !empty;
  assign water_level = level;

`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
  assign ram_we = wr_acc && !rst && !flush;
`else
  assign ram_we = wr_acc && !rst;
`endif

  sync_fifo_dpram #(
    .WORD_W     (WORD_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    level_nxt = level;
    if (wr_acc && !rd_acc)      level_nxt = level + 1'b1;
    else if (rd_acc && !wr_acc) level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end
`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
    else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end
`endif
    else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      level        <= level_nxt;
      full         <= (level_nxt == DEPTH_LVL);
      almost_full  <= (level_nxt >= AF_LVL);
      empty        <= (level_nxt == '0);
      almost_empty <= (level_nxt <= AE_LVL);
    end
  end

  // A fresh error event outranks a clear issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end

  if (FWFT == MODE_FWFT) begin : g_fwft
    assign rd_data = ram_rd_data;
  end else begin : g_std
    logic              rd_load;
    logic [WORD_W-1:0] rd_data_q;
`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
    assign rd_load = rd_acc && !flush;
`else
    assign rd_load = rd_acc;
`endif
    always_ff @(posedge clk) begin
      if (rst)          rd_data_q <= '0;
      else if (rd_load) rd_data_q <= ram_rd_data;
    end
    assign rd_data = rd_data_q;
  end

endmodule

// File: tb/tb_sync_sample_fifo.sv
// Drives a standard-mode and an FWFT-mode FIFO (depth 16) with one stimulus
// stream and compares both against a queue-based reference every cycle.
module tb_sync_sample_fifo;

  localparam int WW    = 48;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_en, rd_en, err_clr;
  logic [WW-1:0] wr_data;
`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
  logic          flush;
`endif

  logic          s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
  logic [WW-1:0] s_rd_data;
  logic [4:0]    s_level;
  logic          f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [WW-1:0] f_rd_data;
  logic [4:0]    f_level;

  sync_sample_fifo #(
    .DATA_WIDTH(24), .CH_NUM(2), .ADDR_WIDTH(4), .FWFT(0),
    .ALMOST_FULL_NUM(11), .ALMOST_EMPTY_NUM(4)
  ) u_std (
    .clk(clk), .rst(rst),
`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .wr_data(wr_data), .wr_en(wr_en), .full(s_full), .almost_full(s_afull),
    .rd_data(s_rd_data), .rd_en(rd_en), .empty(s_empty), .almost_empty(s_aempty),
    .water_level(s_level), .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
  );

  sync_sample_fifo #(
    .DATA_WIDTH(24), .CH_NUM(2), .ADDR_WIDTH(4), .FWFT(1),
    .ALMOST_FULL_NUM(11), .ALMOST_EMPTY_NUM(4)
  ) u_fwft (
    .clk(clk), .rst(rst),
`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .wr_data(wr_data), .wr_en(wr_en), .full(f_full), .almost_full(f_afull),
    .rd_data(f_rd_data), .rd_en(rd_en), .empty(f_empty), .almost_empty(f_aempty),
    .water_level(f_level), .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
  );

  // Reference: contents as a queue, sticky errors, and the standard-mode output word.
  logic [WW-1:0] q[$];
  logic          ovf_m, unf_m;
  logic [WW-1:0] std_rd_m;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(input logic r, input logic w, input logic rd,
                                     input logic [WW-1:0] d, input logic c, input logic fl);
    bit was_full, was_empty;
    if (r) begin
      q.delete();
      ovf_m    = 1'b0;
      unf_m    = 1'b0;
      std_rd_m = '0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (w && was_full)   ovf_m = 1'b1;
    else if (c)          ovf_m = 1'b0;
    if (rd && was_empty) unf_m = 1'b1;
    else if (c)          unf_m = 1'b0;
    if (fl) begin
      q.delete();
      return;
    end
    if (rd && !was_empty) std_rd_m = q.pop_front();
    if (w && !was_full)   q.push_back(d);
  endfunction

  task automatic check_all();
    int lvl;
    lvl = q.size();
    chk("std.level",     64'(s_level),  64'(lvl));
    chk("std.full",      64'(s_full),   64'(lvl == DEPTH));
    chk("std.empty",     64'(s_empty),  64'(lvl == 0));
    chk("std.afull",     64'(s_afull),  64'(lvl >= 11));
    chk("std.aempty",    64'(s_aempty), 64'(lvl <= 4));
    chk("std.overflow",  64'(s_ovf),    64'(ovf_m));
    chk("std.underflow", 64'(s_unf),    64'(unf_m));
    chk("std.rd_data",   64'(s_rd_data), 64'(std_rd_m));
    chk("fwft.level",    64'(f_level),  64'(lvl));
    chk("fwft.empty",    64'(f_empty),  64'(lvl == 0));
    chk("fwft.full",     64'(f_full),   64'(lvl == DEPTH));
    chk("fwft.overflow", 64'(f_ovf),    64'(ovf_m));
    chk("fwft.underflow",64'(f_unf),    64'(unf_m));
    if (lvl > 0) chk("fwft.rd_data", 64'(f_rd_data), 64'(q[0]));
  endtask

  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [WW-1:0] d, input logic c, input logic fl);
    rst = r; wr_en = w; rd_en = rd; wr_data = d; err_clr = c;
`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
    flush = fl;
`endif
    @(posedge clk);
    model_edge(r, w, rd, d, c, fl);
    #1;
    check_all();
  endtask

  function automatic logic [WW-1:0] sample_word(input int i);
    logic [23:0] ch0;
    ch0 = 24'(i);
    return {ch0 + 24'h100000, ch0};
  endfunction

  initial begin
    logic [WW-1:0] marker;
    marker = 48'hBAD000_BAD000;

    // Reset state.
    step(1, 0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, 0);

    // Fill to full with the ordered sample pattern.
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, sample_word(i), 0, 0);

    // Full boundary: read accepted, write rejected, overflow latched; then clear.
    step(0, 1, 1, 48'hDEAD00_DEAD00, 0, 0);
    step(0, 0, 0, '0, 1, 0);

    // Drain in order.
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, '0, 0, 0);

    // Empty boundary: write accepted, read rejected, underflow latched, rd_data held.
    step(0, 1, 1, {24'h123456, 24'hABCDEF}, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 1, '0, 0, 0);
    // Read-while-empty and clear together: the new underflow wins.
    step(0, 0, 1, '0, 1, 0);
    step(0, 0, 0, '0, 1, 0);

    // Randomised interleaving, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 280; i++) begin
      int  wp;
      logic w, rd, c, fl;
      wp = ((i / 35) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      c  = ($urandom_range(0, 15) == 0);
`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
      fl = ($urandom_range(0, 60) == 0);
`else
      fl = 1'b0;
`endif
      step(0, w, rd, {24'($urandom), 24'($urandom)}, c, fl);
    end

    // Reset at level 7 with a write pending: the word must never come out.
    step(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, sample_word(32 + i), 0, 0);
    step(1, 1, 0, marker, 0, 0);
    step(0, 1, 0, sample_word(50), 0, 0);
    step(0, 1, 0, sample_word(51), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0, 0, 0);

`ifdef SYNC_SAMPLE_FIFO_FLUSH_EN
    // Flush at level 5 with a write pending; sticky errors survive the flush.
    step(0, 0, 1, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, sample_word(60 + i), 0, 0);
    step(0, 1, 0, marker, 0, 1);
    step(0, 1, 0, sample_word(70), 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, '0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
